// File: rtl/rf_access_arbiter.sv
// Two-master access arbiter for a 9 x 15 register file: dedicated read ports, round-robin shared write port.
// Optional macro RF_FWD_EN forwards same-cycle write data to a colliding read.
module rf_access_arbiter #(
    parameter int DW    = 15,
    parameter int AW    = 4,
    parameter int DEPTH = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wrd,
    output logic          rf_we,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [7:0]    conflicts
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [1:0]    req_v;
    logic [1:0]    wr_v;
    logic [1:0]    wreq;
    logic [1:0]    wgnt;
    logic [1:0]    rgnt;
    logic [1:0]    avalid;
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];
    logic [DW-1:0] rd_v    [2];
    logic [DW-1:0] rd_sel  [2];

    logic       rr_ptr_reg;
    logic [7:0] conflicts_reg;

    assign req_v      = {req1, req0};
    assign wr_v       = {wr1, wr0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;
    assign rd_v[0]    = rf_rd1;
    assign rd_v[1]    = rf_rd2;

    assign wreq = req_v & wr_v;

    // rr_ptr_reg = 0 favours M0 on a collision, 1 favours M1; all grants are held off during reset.
    assign wgnt[0] = rst_n & wreq[0] & (~wreq[1] | ~rr_ptr_reg);
    assign wgnt[1] = rst_n & wreq[1] & (~wreq[0] |  rr_ptr_reg);

    assign gnt0   = rgnt[0] | wgnt[0];
    assign gnt1   = rgnt[1] | wgnt[1];
    assign rf_ra1 = addr0;
    assign rf_ra2 = addr1;

    always_comb begin
        rf_we  = 1'b0;
        rf_wa  = '0;
        rf_wrd = '0;
        if (wgnt[0]) begin
            rf_we  = avalid[0];
            rf_wa  = addr0;
            rf_wrd = wdata0;
        end else if (wgnt[1]) begin
            rf_we  = avalid[1];
            rf_wa  = addr1;
            rf_wrd = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= 1'b0;
            conflicts_reg <= '0;
        end else begin
            if (wgnt[0])
                rr_ptr_reg <= 1'b1;
            else if (wgnt[1])
                rr_ptr_reg <= 1'b0;
            if (wreq[0] && wreq[1] && conflicts_reg != 8'hFF)
                conflicts_reg <= conflicts_reg + 8'd1;
        end
    end

    assign conflicts = conflicts_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_port
            logic          rvalid_reg;
            logic [DW-1:0] rdata_reg;
            logic          err_reg;

            assign avalid[gi] = {1'b0, addr_v[gi]} < DEPTH_L;
            assign rgnt[gi]   = rst_n & req_v[gi] & ~wr_v[gi];

`ifdef RF_FWD_EN
            // A read only ever collides with the other master's write, so rf_wrd is never this port's own data.
            assign rd_sel[gi] = (rf_we && rf_wa == addr_v[gi]) ? rf_wrd : rd_v[gi];
`else
            assign rd_sel[gi] = rd_v[gi];
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                    err_reg    <= 1'b0;
                end else begin
                    rvalid_reg <= rgnt[gi];
                    err_reg    <= (rgnt[gi] | wgnt[gi]) & ~avalid[gi];
                    if (rgnt[gi])
                        rdata_reg <= avalid[gi] ? rd_sel[gi] : '0;
                end
            end
        end
    endgenerate

    assign rvalid0 = gen_port[0].rvalid_reg;
    assign rvalid1 = gen_port[1].rvalid_reg;
    assign rdata0  = gen_port[0].rdata_reg;
    assign rdata1  = gen_port[1].rdata_reg;
    assign err0    = gen_port[0].err_reg;
    assign err1    = gen_port[1].err_reg;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural register-file model on the RAM ports.
// Build with +define+RF_FWD_EN to expect forwarded data in the hazard step.
module tb_rf_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, wr0, wr1;
    logic [3:0]  addr0, addr1;
    logic [14:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, rf_we;
    logic [14:0] rdata0, rdata1, rf_wrd, rf_rd1, rf_rd2;
    logic [3:0]  rf_ra1, rf_ra2, rf_wa;
    logic [7:0]  conflicts;

    int tests = 0;
    int fails = 0;

    logic [14:0] mem [16];

    rf_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_wrd(rf_wrd),
        .rf_we(rf_we), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .conflicts(conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model; unimplemented addresses return a non-zero pattern so zeroing is visible.
    always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wrd;
    assign rf_rd1 = (rf_ra1 < 4'd9) ? mem[rf_ra1] : 15'h7ABC;
    assign rf_rd2 = (rf_ra2 < 4'd9) ? mem[rf_ra2] : 15'h7ABC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic       turn;
    logic [7:0] exp_cnt;

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, 15'h0);
        chk("rst_rdata1", rdata1, 15'h0);
        chk("rst_err0", err0, 1'b0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_conflicts", conflicts, 8'd0);
        req0 = 1; wr0 = 1; addr0 = 2;
        #1;
        chk("rst_gnt0_gated", gnt0, 1'b0);
        chk("rst_we_gated", rf_we, 1'b0);
        req0 = 0; wr0 = 0; addr0 = 0;
        step();
        rst_n = 1'b1;
        #1;
        chk("idle_we", rf_we, 1'b0);
        chk("idle_gnt0", gnt0, 1'b0);
        chk("idle_gnt1", gnt1, 1'b0);

        // Write collision on addr 3
        req0 = 1; wr0 = 1; addr0 = 3; wdata0 = 15'h0AAA;
        req1 = 1; wr1 = 1; addr1 = 3; wdata1 = 15'h0555;
        #1;
        chk("coll1_gnt0", gnt0, 1'b1);
        chk("coll1_gnt1", gnt1, 1'b0);
        chk("coll1_wrd", rf_wrd, 15'h0AAA);
        step();
        chk("coll1_conflicts", conflicts, 8'd1);
        req0 = 0; wr0 = 0;
        #1;
        chk("coll2_gnt1", gnt1, 1'b1);
        chk("coll2_wa", rf_wa, 4'd3);
        chk("coll2_wrd", rf_wrd, 15'h0555);
        step();
        chk("coll2_conflicts", conflicts, 8'd1);
        req1 = 0; wr1 = 0;
        req0 = 1; wr0 = 0; addr0 = 3;
        #1;
        chk("rd3_gnt0", gnt0, 1'b1);
        chk("rd3_ra1", rf_ra1, 4'd3);
        chk("rd3_we", rf_we, 1'b0);
        chk("rd3_wa_idle", rf_wa, 4'd0);
        chk("rd3_wrd_idle", rf_wrd, 15'h0);
        step();
        chk("rd3_rvalid0", rvalid0, 1'b1);
        chk("rd3_rdata0", rdata0, 15'h0555);

        // Read steering: write addr 2 then both read it
        wr0 = 1; addr0 = 2; wdata0 = 15'h1234;
        #1;
        chk("wr2_gnt0", gnt0, 1'b1);
        chk("wr2_we", rf_we, 1'b1);
        chk("wr2_wa", rf_wa, 4'd2);
        chk("wr2_wrd", rf_wrd, 15'h1234);
        step();
        chk("wr2_rvalid0", rvalid0, 1'b0);
        chk("wr2_rdata0_hold", rdata0, 15'h0555);
        wr0 = 0; addr0 = 2;
        req1 = 1; wr1 = 0; addr1 = 2;
        #1;
        chk("rd2_gnt0", gnt0, 1'b1);
        chk("rd2_gnt1", gnt1, 1'b1);
        chk("rd2_ra2", rf_ra2, 4'd2);
        step();
        chk("rd2_rvalid0", rvalid0, 1'b1);
        chk("rd2_rvalid1", rvalid1, 1'b1);
        chk("rd2_rdata0", rdata0, 15'h1234);
        chk("rd2_rdata1", rdata1, 15'h1234);

        // Invalid addresses
        req0 = 0;
        wr1 = 1; addr1 = 9; wdata1 = 15'h7FFF;
        #1;
        chk("bad_wr_gnt1", gnt1, 1'b1);
        chk("bad_wr_we", rf_we, 1'b0);
        step();
        chk("bad_wr_err1", err1, 1'b1);
        chk("bad_wr_err0", err0, 1'b0);
        req1 = 0; wr1 = 0;
        req0 = 1; wr0 = 0; addr0 = 12;
        #1;
        chk("bad_rd_gnt0", gnt0, 1'b1);
        step();
        chk("bad_rd_err0", err0, 1'b1);
        chk("bad_rd_err1_pulse", err1, 1'b0);
        chk("bad_rd_rvalid0", rvalid0, 1'b1);
        chk("bad_rd_rdata0", rdata0, 15'h0);

        // Hazard: M1 writes addr 4 while M0 reads it
        wr0 = 1; addr0 = 4; wdata0 = 15'h0011;
        step();
        chk("haz_err0_clear", err0, 1'b0);
        wr0 = 0;
        req1 = 1; wr1 = 1; addr1 = 4; wdata1 = 15'h0022;
        #1;
        chk("haz_gnt0", gnt0, 1'b1);
        chk("haz_gnt1", gnt1, 1'b1);
        chk("haz_we", rf_we, 1'b1);
        step();
`ifdef RF_FWD_EN
        chk("haz_rdata0", rdata0, 15'h0022);
`else
        chk("haz_rdata0", rdata0, 15'h0011);
`endif
        chk("haz_conflicts", conflicts, 8'd1);

        // Saturation: continuous collisions, grants alternate starting with M0
        req0 = 1; wr0 = 1; addr0 = 5; wdata0 = 15'h0101;
        req1 = 1; wr1 = 1; addr1 = 6; wdata1 = 15'h0202;
        turn = 1'b0;
        exp_cnt = 8'd1;
        for (int i = 0; i < 300; i++) begin
            #1;
            chk("sat_gnt0", gnt0, !turn);
            chk("sat_gnt1", gnt1, turn);
            chk("sat_conflicts", conflicts, exp_cnt);
            step();
            turn = ~turn;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        chk("sat_final", conflicts, 8'd255);

        // Reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("mrst_conflicts", conflicts, 8'd0);
        chk("mrst_we", rf_we, 1'b0);
        chk("mrst_gnt0", gnt0, 1'b0);
        chk("mrst_gnt1", gnt1, 1'b0);
        chk("mrst_rvalid0", rvalid0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt0", gnt0, 1'b1);
        chk("post_rst_gnt1", gnt1, 1'b0);
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
